// File: rtl/raster_scheduler.sv
// Raster scan sequencer for the pixel packer: owns the x/y counters, frame start/stop
// control and the per-frame source selection between two RGB generators.
module raster_scheduler #(
  parameter int unsigned X_SIZE = 640,
  parameter int unsigned Y_SIZE = 480,
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 9
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          enable,
  input  logic          src_sel,
  input  logic [23:0]   src0_rgb,
  input  logic [23:0]   src1_rgb,
  input  logic          in_stream_ready,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic          valid,
  output logic          sof,
  output logic          eol,
  output logic          active_sel,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_count
);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  localparam logic [XW-1:0] XLast = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] YLast = YW'(Y_SIZE - 1);

  logic          state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          active_sel_q, active_sel_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_count_q, frame_count_d;

  logic          run;
  logic          hs;
  logic          x_last;
  logic          y_last;
  logic [23:0]   rgb_mux;

  assign run    = (state_q == StRun);
  assign hs     = run & in_stream_ready;
  assign x_last = (x_q == XLast);
  assign y_last = (y_q == YLast);

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    active_sel_d  = active_sel_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    if (state_q == StIdle) begin
      x_d = '0;
      y_d = '0;
      if (enable) begin
        state_d      = StRun;
        active_sel_d = src_sel;
      end
    end else if (hs) begin
      if (!x_last) begin
        x_d = x_q + 1'b1;
      end else begin
        x_d = '0;
        if (!y_last) begin
          y_d = y_q + 1'b1;
        end else begin
          // Frame boundary: the only point where the source may change or streaming stop.
          y_d           = '0;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          if (enable) begin
            active_sel_d = src_sel;
          end else begin
            state_d = StIdle;
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      active_sel_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_sel_q  <= active_sel_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign rgb_mux = active_sel_q ? src1_rgb : src0_rgb;

  assign x           = x_q;
  assign y           = y_q;
  assign r           = rgb_mux[23:16];
  assign g           = rgb_mux[15:8];
  assign b           = rgb_mux[7:0];
  assign valid       = run;
  assign sof         = run & (x_q == '0) & (y_q == '0);
  assign eol         = run & x_last;
  assign busy        = run;
  assign active_sel  = active_sel_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_raster_scheduler.sv
// Directed bench for raster_scheduler on a 4x3 raster, plus a 1x1 instance that
// reaches the 16-bit frame counter wrap within a short run.
module tb_raster_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        src_sel;
  logic        ready;
  logic [23:0] src0_rgb;
  logic [23:0] src1_rgb;
  logic [1:0]  x;
  logic [1:0]  y;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol, active_sel, busy, frame_done;
  logic [15:0] frame_count;

  logic        en_w;
  logic [0:0]  x_w, y_w;
  logic [7:0]  r_w, g_w, b_w;
  logic        valid_w, sof_w, eol_w, asel_w, busy_w, fd_w;
  logic [15:0] fc_w;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  function automatic logic [23:0] c0(int xi, int yi);
    return {8'(16 + xi), 8'(32 + yi), 8'h5A};
  endfunction

  function automatic logic [23:0] c1(int xi, int yi);
    return {8'(160 + xi), 8'(192 + yi), 8'hC3};
  endfunction

  assign src0_rgb = c0(int'(x), int'(y));
  assign src1_rgb = c1(int'(x), int'(y));

  raster_scheduler #(.X_SIZE(4), .Y_SIZE(3), .XW(2), .YW(2)) u_dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .enable          (enable),
    .src_sel         (src_sel),
    .src0_rgb        (src0_rgb),
    .src1_rgb        (src1_rgb),
    .in_stream_ready (ready),
    .x               (x),
    .y               (y),
    .r               (r),
    .g               (g),
    .b               (b),
    .valid           (valid),
    .sof             (sof),
    .eol             (eol),
    .active_sel      (active_sel),
    .busy            (busy),
    .frame_done      (frame_done),
    .frame_count     (frame_count)
  );

  raster_scheduler #(.X_SIZE(1), .Y_SIZE(1), .XW(1), .YW(1)) u_wrap (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .enable          (en_w),
    .src_sel         (1'b0),
    .src0_rgb        (24'h123456),
    .src1_rgb        (24'h654321),
    .in_stream_ready (1'b1),
    .x               (x_w),
    .y               (y_w),
    .r               (r_w),
    .g               (g_w),
    .b               (b_w),
    .valid           (valid_w),
    .sof             (sof_w),
    .eol             (eol_w),
    .active_sel      (asel_w),
    .busy            (busy_w),
    .frame_done      (fd_w),
    .frame_count     (fc_w)
  );

  task automatic do_reset();
    aresetn = 1'b0;
    enable  = 1'b0;
    src_sel = 1'b0;
    ready   = 1'b1;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic drain();
    enable = 1'b0;
    ready  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge aclk);
      if (!busy) break;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout busy got %0b exp 0", busy);
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    aresetn = 1'b0;
    enable  = 1'b0;
    src_sel = 1'b1;
    ready   = 1'b1;
    en_w    = 1'b0;
    @(negedge aclk);
    got = {valid, sof, eol, busy, frame_done, active_sel, x == 2'd0, y == 2'd0};
    checks++;
    if (got !== 8'b0000_0011) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000011", got);
    end
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count got %h exp 0000", frame_count);
    end
    checks++;
    if ({r, g, b} !== c0(0, 0)) begin
      errors++;
      $display("FAIL reset_rgb got %h exp %h", {r, g, b}, c0(0, 0));
    end
    aresetn = 1'b1;
    src_sel = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_basic_frame();
    logic [31:0] got, exp;
    do_reset();
    enable = 1'b1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL pre_enable_valid got %0b exp 0", valid);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk);
      got = {frame_done, valid, sof, eol, x, y, r, g, b};
      exp = {1'b0, 1'b1, i == 0, (i % 4) == 3, 2'(i % 4), 2'(i / 4), c0(i % 4, i / 4)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic_px%0d got %h exp %h", i, got, exp);
      end
    end
    @(negedge aclk);
    got = {frame_done, valid, sof, eol, x, y, r, g, b};
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, c0(0, 0)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL basic_frame_end got %h exp %h", got, exp);
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL basic_count got %h exp 0001", frame_count);
    end
    @(negedge aclk);
    checks++;
    if ({frame_done, valid, x, y} !== {1'b0, 1'b1, 2'd1, 2'd0}) begin
      errors++;
      $display("FAIL basic_next_frame got %b exp 010100", {frame_done, valid, x, y});
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [39:0] pat;
    logic [31:0] got, exp;
    int n;
    pat = 40'b1001_1011_0010_1110_0101_1001_1101_0011_1011_0110;
    n = 0;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 40 && n < 12; k++) begin
      @(negedge aclk);
      got = {frame_done, valid, sof, eol, x, y, r, g, b};
      exp = {1'b0, 1'b1, n == 0, (n % 4) == 3, 2'(n % 4), 2'(n / 4), c0(n % 4, n / 4)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bp_cycle%0d got %h exp %h", k, got, exp);
      end
      enable = 1'b0;
      ready  = pat[k];
      if (pat[k]) n++;
    end
    checks++;
    if (n !== 12) begin
      errors++;
      $display("FAIL bp_accepted got %0d exp 12", n);
    end
    @(negedge aclk);
    checks++;
    if ({frame_done, valid, busy, x, y} !== 7'b100_0000) begin
      errors++;
      $display("FAIL bp_end got %b exp 1000000", {frame_done, valid, busy, x, y});
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL bp_count got %h exp 0001", frame_count);
    end
    ready = 1'b1;
  endtask

  task automatic test_src_switch();
    logic [24:0] got, exp;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk);
      got = {active_sel, r, g, b};
      exp = {1'b0, c0(i % 4, i / 4)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL src_px%0d got %h exp %h", i, got, exp);
      end
      if (i == 6) src_sel = 1'b1;
    end
    @(negedge aclk);
    got = {active_sel, r, g, b};
    exp = {1'b1, c1(0, 0)};
    checks++;
    if (got !== exp || sof !== 1'b1) begin
      errors++;
      $display("FAIL src_switch got %h sof %0b exp %h sof 1", got, sof, exp);
    end
    drain();
    src_sel = 1'b0;
  endtask

  task automatic test_enable_drop();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk);
      checks++;
      if ({valid, x, y} !== {1'b1, 2'(i % 4), 2'(i / 4)}) begin
        errors++;
        $display("FAIL drop_px%0d got %b exp %b", i, {valid, x, y}, {1'b1, 2'(i % 4), 2'(i / 4)});
      end
      if (i == 1) enable = 1'b0;
    end
    @(negedge aclk);
    checks++;
    if ({frame_done, valid, busy, x, y} !== 7'b100_0000) begin
      errors++;
      $display("FAIL drop_end got %b exp 1000000", {frame_done, valid, busy, x, y});
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL drop_count got %h exp 0001", frame_count);
    end
    @(negedge aclk);
    checks++;
    if ({frame_done, valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL drop_idle got %b exp 000", {frame_done, valid, busy});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 7; i++) @(negedge aclk);
    checks++;
    if ({x, y} !== {2'd2, 2'd1}) begin
      errors++;
      $display("FAIL arst_pre got %b exp 1001", {x, y});
    end
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({valid, sof, eol, busy, frame_done, x, y} !== 9'd0) begin
      errors++;
      $display("FAIL arst_immediate got %b exp 0", {valid, sof, eol, busy, frame_done, x, y});
    end
    checks++;
    if (frame_count !== 16'd0 || {r, g, b} !== c0(0, 0)) begin
      errors++;
      $display("FAIL arst_count_rgb got %h %h exp 0000 %h", frame_count, {r, g, b}, c0(0, 0));
    end
    enable = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      checks++;
      if ({frame_done, busy, frame_count} !== 18'd0) begin
        errors++;
        $display("FAIL arst_after%0d got %h exp 0", k, {frame_done, busy, frame_count});
      end
    end
  endtask

  task automatic test_count_wrap();
    en_w = 1'b1;
    for (int k = 0; k < 70000; k++) begin
      @(negedge aclk);
      if (fc_w == 16'hFFFF) break;
    end
    checks++;
    if (fc_w !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload got %h exp ffff", fc_w);
    end
    @(negedge aclk);
    checks++;
    if ({fd_w, fc_w} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_count got fd %0b cnt %h exp fd 1 cnt 0000", fd_w, fc_w);
    end
    en_w = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    enable  = 1'b0;
    src_sel = 1'b0;
    ready   = 1'b1;
    en_w    = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_src_switch();
    test_enable_drop();
    test_async_reset();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raster_scheduler.md
Name: raster_scheduler

Overview:
- Sequences the raster scan that feeds the pixel packer: owns the x/y counters and the frame start/stop control.
- Drives the packer's valid, sof and eol inputs and honours the packer's in_stream_ready backpressure.
- Shares the single packer between two pixel sources by muxing their RGB, switching sources only at frame boundaries.
- Sits between the pixel generators and the packer, ahead of the AXI-Stream video output.

Parameters:
- X_SIZE, 640, active pixels per line.
- Y_SIZE, 480, active lines per frame.
- XW, 10, x counter width; must satisfy 2^XW >= X_SIZE.
- YW, 9, y counter width; must satisfy 2^YW >= Y_SIZE.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous, active-low.
- enable  in  1  level request to stream frames.
- src_sel  in  1  source select request; 0 = src0, 1 = src1.
- src0_rgb  in  24  {r,g,b} from source 0 for the current x,y.
- src1_rgb  in  24  {r,g,b} from source 1 for the current x,y.
- in_stream_ready  in  1  packer ready.
- x  out  XW  current pixel column.
- y  out  YW  current pixel row.
- r, g, b  out  8 each  muxed colour to the packer.
- valid  out  1  pixel valid to the packer.
- sof  out  1  first pixel of frame.
- eol  out  1  last pixel of line.
- active_sel  out  1  source latched for the current frame.
- busy  out  1  high while not IDLE.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_count  out  16  number of completed frames; wraps.

Behaviour:
- Reset (aresetn low, asynchronous) forces: state IDLE; x=0, y=0, active_sel=0, frame_done=0, frame_count=0.
- Under reset, valid, sof, eol and busy are 0 and r,g,b equal src0_rgb.
- A reset mid-frame abandons the frame immediately; no frame_done and no count increment are produced.
- States:
  - IDLE: valid=0, x=y=0.
  - RUN: valid=1.
- Handshake: hs = valid & in_stream_ready.
- Combinational outputs:
  - sof = RUN & x==0 & y==0.
  - eol = RUN & x==X_SIZE-1.
  - busy = RUN.
  - {r,g,b} = active_sel ? src1_rgb : src0_rgb.
- x, y, active_sel and frame_count are registered.
- IDLE->RUN: enable sampled high at a clock edge.
  - State becomes RUN on that edge with active_sel <= src_sel.
  - The first valid pixel (0,0) appears in the following cycle, i.e. 1 cycle latency.
- In RUN, on hs:
  - If x != X_SIZE-1: x <= x+1.
  - Otherwise x <= 0, and y advances:
    - If y != Y_SIZE-1: y <= y+1.
    - Otherwise end of frame: y <= 0.
- With in_stream_ready low, x, y, valid, sof, eol and active_sel hold stable. The packer may stall for any number of cycles.
- End of frame (hs at x=X_SIZE-1, y=Y_SIZE-1):
  - frame_done pulses in the next cycle.
  - frame_count increments, wrapping 0xFFFF->0.
  - If enable=1 at that edge: stay RUN and relatch active_sel <= src_sel, so back-to-back frames have no bubble.
  - If enable=0: go to IDLE.
- enable deasserted mid-frame: the current frame completes in full; the block stops only at end of frame.
- enable re-asserted before end of frame: streaming continues uninterrupted.
- src_sel changes mid-frame are ignored until the next frame boundary; active_sel never changes while sof=0 in RUN.
- The counters never exceed X_SIZE-1 or Y_SIZE-1; there are no out-of-range values.

Test Plan:
- All tests use X_SIZE=4, Y_SIZE=3, XW=2, YW=2.
- Reset then enable=1, ready=1 constant: valid rises 1 cycle after enable is sampled. Pixels go (0,0),(1,0)..(3,2) over 12 cycles. sof only on (0,0); eol on x=3 for y=0,1,2. frame_done pulses once after pixel 12; frame_count=1; the next frame starts with no gap.
- Toggle ready 1,0,0,1 pseudo-randomly during a frame: exactly 12 accepted pixels in order. x, y and colour are held while ready=0.
- src_sel 0->1 at pixel (2,1): r,g,b stay on src0 through (3,2), then switch to src1 at the next sof; active_sel=1 from that frame.
- enable dropped at pixel (1,0): the frame completes to (3,2), frame_done pulses, state returns to IDLE, valid=0, x=y=0, busy=0.
- aresetn pulsed low asynchronously at pixel (2,1): outputs zero immediately without waiting for a clock edge; frame_count is unchanged from its pre-frame value; there is no frame_done.
- Preload frame_count=0xFFFF via 65535 frames (or a forced value): the next frame end gives frame_count=0x0000 with a frame_done pulse.
